// File: rtl/alu_issue_queue.sv
// alu_issue_queue: operand issue stage in front of the 32-bit ripple ALU.
//   Buffers {dataA, dataB, funct} ops in a DEPTH-entry FIFO. Drives the head
//   entry combinationally onto the ALU inputs, and captures the ALU result into
//   a valid/ready output register. Unsupported funct codes yield out_data=0
//   with out_err=1.
// Ports:
//   clk, reset (async, active-low)
//   in_valid/in_ready, in_dataA, in_dataB, in_funct   upstream op handshake
//   alu_dataA, alu_dataB, alu_Signal                   head entry to the ALU (combinational)
//   alu_dataOut                                        ALU result (same cycle)
//   out_valid/out_ready, out_data, out_err             result handshake
// Optional feature (macro ALU_ISSUE_STATS_EN):
//   stat_ops[15:0], stat_err[15:0]: saturating issue / error-issue counters.
module alu_issue_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_dataA,
    input  logic [31:0] in_dataB,
    input  logic [5:0]  in_funct,
    output logic [31:0] alu_dataA,
    output logic [31:0] alu_dataB,
    output logic [5:0]  alu_Signal,
    input  logic [31:0] alu_dataOut,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
`ifdef ALU_ISSUE_STATS_EN
    output logic [15:0] stat_ops,
    output logic [15:0] stat_err,
`endif
    output logic        out_err
);

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned FUNCT_W = 6;
    localparam int unsigned CNT_W   = PTR_W + 1;

    typedef struct packed {
        logic [DATA_W-1:0]  a;
        logic [DATA_W-1:0]  b;
        logic [FUNCT_W-1:0] funct;
    } op_t;

    op_t               mem_q [DEPTH];
    op_t               mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_err_q, out_err_d;

    logic push_c;
    logic pop_c;
    logic legal_c;
    op_t  head_c;

    // Handshake decisions; a full queue refuses pushes even when popping.
    always_comb begin
        in_ready = (count_q != CNT_W'(DEPTH));
        push_c   = in_valid && in_ready;
        pop_c    = (count_q != '0) && (!out_valid_q || out_ready);
    end

    // Head entry onto the ALU; an empty queue presents an all-zero NOP.
    always_comb begin
        head_c = '0;
        if (count_q != '0) begin
            head_c = mem_q[rd_ptr_q];
        end
    end

    assign alu_dataA  = head_c.a;
    assign alu_dataB  = head_c.b;
    assign alu_Signal = head_c.funct;

    // Funct codes the ALU implements: ADD, SUB, AND, OR, SLT.
    always_comb begin
        legal_c = 1'b0;
        case (head_c.funct)
            6'd32, 6'd34, 6'd36, 6'd37, 6'd42: legal_c = 1'b1;
            default:                           legal_c = 1'b0;
        endcase
    end

    // Next-state for FIFO storage, pointers, count and result register.
    always_comb begin
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_err_d   = out_err_q;

        if (push_c) begin
            mem_d[wr_ptr_q] = '{a: in_dataA, b: in_dataB, funct: in_funct};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end

        if (pop_c) begin
            rd_ptr_d    = rd_ptr_q + PTR_W'(1);
            out_valid_d = 1'b1;
            out_data_d  = legal_c ? alu_dataOut : '0;
            out_err_d   = !legal_c;
        end else if (out_valid_q && out_ready) begin
            // Drain: data/err keep their last value.
            out_valid_d = 1'b0;
        end

        case ({push_c, pop_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_err_q   <= 1'b0;
        end else begin
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_err_q   <= out_err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_err   = out_err_q;

`ifdef ALU_ISSUE_STATS_EN
    localparam int unsigned STAT_W = 16;

    logic [STAT_W-1:0] stat_ops_q, stat_ops_d;
    logic [STAT_W-1:0] stat_err_q, stat_err_d;

    // Saturating issue counters.
    always_comb begin
        stat_ops_d = stat_ops_q;
        stat_err_d = stat_err_q;
        if (pop_c && (stat_ops_q != '1)) begin
            stat_ops_d = stat_ops_q + STAT_W'(1);
        end
        if (pop_c && !legal_c && (stat_err_q != '1)) begin
            stat_err_d = stat_err_q + STAT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_ops_q <= '0;
            stat_err_q <= '0;
        end else begin
            stat_ops_q <= stat_ops_d;
            stat_err_q <= stat_err_d;
        end
    end

    assign stat_ops = stat_ops_q;
    assign stat_err = stat_err_q;
`endif

endmodule

// File: tb/tb_alu_issue_queue.sv
// tb_alu_issue_queue: self-checking bench for alu_issue_queue.
//   Models the ALU combinationally and keeps a queue-based reference of the
//   issue stage (ops waiting + one held result) to predict every output.
module tb_alu_issue_queue;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_dataA;
    logic [31:0] in_dataB;
    logic [5:0]  in_funct;
    logic [31:0] alu_dataA;
    logic [31:0] alu_dataB;
    logic [5:0]  alu_Signal;
    logic [31:0] alu_dataOut;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_err;
`ifdef ALU_ISSUE_STATS_EN
    logic [15:0] stat_ops;
    logic [15:0] stat_err;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_issue_queue #(.DEPTH(DEPTH), .PTR_W(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_dataA    (in_dataA),
        .in_dataB    (in_dataB),
        .in_funct    (in_funct),
        .alu_dataA   (alu_dataA),
        .alu_dataB   (alu_dataB),
        .alu_Signal  (alu_Signal),
        .alu_dataOut (alu_dataOut),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
`ifdef ALU_ISSUE_STATS_EN
        .stat_ops    (stat_ops),
        .stat_err    (stat_err),
`endif
        .out_err     (out_err)
    );

    // Behavioural ALU; unimplemented codes give junk so zeroing is visible.
    function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                          input logic [5:0] f);
        case (f)
            6'd32:   return a + b;
            6'd34:   return a - b;
            6'd36:   return a & b;
            6'd37:   return a | b;
            6'd42:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            6'd39:   return ~(a | b);
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    function automatic logic is_legal(input logic [5:0] f);
        return (f == 6'd32) || (f == 6'd34) || (f == 6'd36) || (f == 6'd37) || (f == 6'd42);
    endfunction

    assign alu_dataOut = alu_f(alu_dataA, alu_dataB, alu_Signal);

    // Reference model: pending ops plus the single held result.
    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [5:0]  f;
    } op_s;

    op_s         mq[$];
    logic        m_v;
    logic [31:0] m_d;
    logic        m_e;
    int          m_ops;
    int          m_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_v   = 1'b0;
        m_d   = '0;
        m_e   = 1'b0;
        m_ops = 0;
        m_err = 0;
    endtask

    // One clock: drive inputs, check outputs against model, advance both.
    task automatic cycle(input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic [5:0] f, input logic ordy);
        logic m_push;
        logic m_pop;
        op_s  h;
        in_valid  = v;
        in_dataA  = a;
        in_dataB  = b;
        in_funct  = f;
        out_ready = ordy;
        #1;
        chk("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
        chk("out_valid", 32'(out_valid), 32'(m_v));
        chk("out_data", out_data, m_d);
        chk("out_err", 32'(out_err), 32'(m_e));
        if (mq.size() != 0) begin
            chk("alu_dataA", alu_dataA, mq[0].a);
            chk("alu_dataB", alu_dataB, mq[0].b);
            chk("alu_Signal", 32'(alu_Signal), 32'(mq[0].f));
        end else begin
            chk("alu_idle", {alu_dataA ^ alu_dataB, 26'(0), alu_Signal} | alu_dataA, 32'd0);
        end
`ifdef ALU_ISSUE_STATS_EN
        chk("stat_ops", 32'(stat_ops), 32'(m_ops));
        chk("stat_err", 32'(stat_err), 32'(m_err));
`endif
        m_pop  = (mq.size() != 0) && (!m_v || ordy);
        m_push = v && (mq.size() < DEPTH);
        @(posedge clk);
        if (m_pop) begin
            h   = mq.pop_front();
            m_v = 1'b1;
            m_d = is_legal(h.f) ? alu_f(h.a, h.b, h.f) : 32'd0;
            m_e = !is_legal(h.f);
            if (m_ops < 65535) m_ops++;
            if (!is_legal(h.f) && m_err < 65535) m_err++;
        end else if (m_v && ordy) begin
            m_v = 1'b0;
        end
        if (m_push) mq.push_back('{a: a, b: b, f: f});
        @(negedge clk);
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [5:0]  f;
        logic [31:0] exp_d;
        logic        exp_e;
    } vec_t;

    vec_t        vecs[8];
    logic [5:0]  fset[8];

    initial begin
        vecs[0] = '{a: 32'd5,         b: 32'd3,         f: 6'd32, exp_d: 32'd8,         exp_e: 1'b0};
        vecs[1] = '{a: 32'd3,         b: 32'd5,         f: 6'd34, exp_d: 32'hFFFF_FFFE, exp_e: 1'b0};
        vecs[2] = '{a: 32'd3,         b: 32'd5,         f: 6'd42, exp_d: 32'd1,         exp_e: 1'b0};
        vecs[3] = '{a: 32'd1,         b: 32'd2,         f: 6'd39, exp_d: 32'd0,         exp_e: 1'b1};
        vecs[4] = '{a: 32'h0000_F0F0, b: 32'h0000_FF00, f: 6'd36, exp_d: 32'h0000_F000, exp_e: 1'b0};
        vecs[5] = '{a: 32'h0000_F0F0, b: 32'h0000_FF00, f: 6'd37, exp_d: 32'h0000_FFF0, exp_e: 1'b0};
        vecs[6] = '{a: 32'hFFFF_FFFF, b: 32'd1,         f: 6'd42, exp_d: 32'd1,         exp_e: 1'b0};
        vecs[7] = '{a: 32'd7,         b: 32'd9,         f: 6'd0,  exp_d: 32'd0,         exp_e: 1'b1};
        fset    = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42, 6'd39, 6'd0, 6'd63};

        in_valid  = 1'b0;
        in_dataA  = '0;
        in_dataB  = '0;
        in_funct  = '0;
        out_ready = 1'b0;
        reset     = 1'b0;
        model_reset();

        // Reset state.
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_err", 32'(out_err), 32'd0);
        chk("rst_alu_dataA", alu_dataA, 32'd0);
        chk("rst_alu_Signal", 32'(alu_Signal), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);

        // Directed vectors: single op into an empty queue, one-cycle latency.
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, vecs[i].a, vecs[i].b, vecs[i].f, 1'b1);
            chk("lat_not_yet", 32'(out_valid), 32'd0);
            cycle(1'b0, '0, '0, '0, 1'b0);
            chk("vec_valid", 32'(out_valid), 32'd1);
            chk("vec_data", out_data, vecs[i].exp_d);
            chk("vec_err", 32'(out_err), 32'(vecs[i].exp_e));
            cycle(1'b0, '0, '0, '0, 1'b1);
        end
        chk("drain_hold_data", out_data, 32'd0);
        chk("drain_valid", 32'(out_valid), 32'd0);

        // Backpressure: 4 queued + 1 held fills the stage.
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 32'(i * 11), 32'(i), 6'd32, 1'b0);
        end
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_head", out_data, 32'd0);
        cycle(1'b1, 32'd100, 32'd1, 6'd32, 1'b0);
        // Push while full and popping is still refused.
        cycle(1'b1, 32'd200, 32'd1, 6'd32, 1'b1);
        for (int i = 0; i < 8; i++) cycle(1'b0, '0, '0, '0, 1'b1);
        chk("full_drained", 32'(out_valid), 32'd0);

        // Async reset mid-operation discards queued ops and held result.
        for (int i = 0; i < 4; i++) cycle(1'b1, 32'(i + 1), 32'd1, 6'd32, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        chk("async_out_valid", 32'(out_valid), 32'd0);
        chk("async_out_data", out_data, 32'd0);
        chk("async_alu_dataA", alu_dataA, 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        cycle(1'b1, 32'd40, 32'd2, 6'd34, 1'b1);
        cycle(1'b0, '0, '0, '0, 1'b1);
        chk("post_rst_first", out_data, 32'd38);

        // Randomised traffic against the reference model.
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 3) != 0, $urandom, $urandom,
                  fset[$urandom_range(0, 7)], $urandom_range(0, 2) != 0);
        end
        for (int i = 0; i < 8; i++) cycle(1'b0, '0, '0, '0, 1'b1);

`ifdef ALU_ISSUE_STATS_EN
        // Saturation of the issue counter with only legal ops.
        reset = 1'b0;
        #1;
        model_reset();
        @(negedge clk);
        reset     = 1'b1;
        in_valid  = 1'b1;
        in_dataA  = 32'd1;
        in_dataB  = 32'd2;
        in_funct  = 6'd32;
        out_ready = 1'b1;
        repeat (65600) @(posedge clk);
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("stat_ops_sat", 32'(stat_ops), 32'h0000_FFFF);
        chk("stat_err_zero", 32'(stat_err), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
